noiseblanker2: RTL
==================

# noiseblanker2

Parametrised second-generation impulse noise blanker for the complex baseband (I/Q) receive path, placed between the decimating filter chain and the demodulator. It estimates each sample's magnitude and flags impulses against either an absolute limit or a limit relative to a running average. Because samples pass through a look-ahead delay line, blanking starts before the impulse emerges and extends a programmable hold time after it. The output is zeroed, held at the last good sample, or passed through. The block also reports a peak magnitude and an impulse event count.

## Interface
- W, 18: sample width, two's complement, per channel
- DEPTH, 4: look-ahead delay in samples (power of two, 2..64); also the pre-blank length
- HOLD, 4: post-blank length in samples after the impulse sample (0..255)
- AVGSH, 8: averager shift, time constant 2^AVGSH samples
- clk  in  1  single clock; all logic on the rising edge
- rstn  in  1  asynchronous, active-low reset
- dix, diy  in  W  I/Q input sample
- iv  in  1  input valid strobe; back-to-back strobes are allowed
- limit  in  12  threshold: absolute (mag12 units) or relative (units of avg/16)
- rel  in  1  0 = absolute threshold, 1 = relative threshold
- mode  in  2  00 bypass, 01 blank to zero, 10 hold last good, 11 treated as 01
- pkrst  in  1  synchronous clear of peak and nbl
- dox, doy  out  W  I/Q output sample
- ov  out  1  output valid strobe, one cycle wide
- peak  out  12  maximum mag12 since the last pkrst
- nbl  out  16  impulse detections since the last pkrst, saturating at 0xFFFF

## Operation
- Magnitude, width W+1: mag = max(|x|,|y|) + min(|x|,|y|)>>1.
  - |x| of the most negative value saturates to 2^(W-1)-1.
  - mag12 = mag[W:W-11].
- Impulse detection, evaluated for each iv sample:
  - Absolute (rel=0): pulse = mag12 > limit.
  - Relative (rel=1): pulse = (mag<<4) > avg*limit and avg != 0. The product is full precision (W+13 bits).
- Averager: on every iv, avg += (mag - avg) >>> AVGSH, using arithmetic shift and a W+1-bit register. Impulse samples are included. Reset value is 0.
- Delay line: DEPTH entries per channel, written on iv. The read order gives sample n-DEPTH while sample n is written. All entries reset to 0.
- Blank counter, 8+ bits:
  - On pulse, load DEPTH+HOLD+1. A pulse arriving while the counter is nonzero reloads it; it does not add.
  - Decrement once per output sample while nonzero.
  - An output sample is blanked while the counter is nonzero. This covers input samples n-DEPTH through n+HOLD around impulse sample n.
- Output selection:
  - mode 00: the delayed sample is passed unchanged. Detection, peak and nbl still operate.
  - mode 01: a blanked sample is output as 0.
  - mode 10: a blanked sample is replaced by the last unblanked output. That register resets to 0.
- Statistics:
  - peak = max(peak, mag12) on each iv.
  - nbl increments on each pulse.
  - pkrst has priority: when it is asserted, both clear to 0 and that cycle's sample does not contribute.
- limit, rel and mode are sampled at the moment they are used. Changes mid-stream take effect on the next sample with no glitch requirement.

## Timing
- Pipeline:
  - iv at cycle t registers the input.
  - Magnitude is ready at t+1.
  - The pulse decision, blank-counter update and delay-line access occur at t+2.
  - dox/doy/ov are registered at t+3.
- Latency: ov is asserted 3 cycles after iv and carries sample n-DEPTH.
  - The first DEPTH outputs after reset are 0.
  - Each output is blanked or not according to the counter state including the pulse decision for sample n (same-cycle load has priority over decrement).
- Throughput: one sample per cycle. ov is never asserted without a corresponding iv.
- dox/doy hold their value between ov strobes.
- Reset (rstn low, asynchronous) forces the following to 0: dox, doy, ov, peak, nbl, avg, the blank counter, the delay line, the hold register and all pipeline valids.
  - A sample in flight when reset asserts is lost.
  - The first iv after rstn rises is handled as sample 0.

## Test plan
Default parameters throughout (W=18, DEPTH=4, HOLD=4).
- Absolute blanking, rel=0, mode=01, limit=10. Feed sparse iv samples, each followed by 6 idle cycles: (100,-100), (1000,-100), (-100,100), (100,-10000), (100,-100).
  - mag12 values are 1, 8, 1, 78, 1, so only the 4th sample is an impulse.
  - Required: nbl=1, peak=78.
  - Outputs for input samples 0..8 around the impulse are 0; other samples are reproduced exactly after the 4-sample delay.
- Latency: a single iv after reset produces ov exactly 3 cycles later with value (0,0). Input sample k appears on the ov that follows input k+4.
- Hold mode: mode=10, with a constant (500,500) stream and one (0,20000) impulse. All blanked outputs equal (500,500).
- Retrigger: two impulses 3 samples apart. The blank window runs from 4 samples before the first impulse to 4 samples after the second, continuously, and nbl=2.
- Relative mode: rel=1, limit=48 (3×avg).
  - Hold a 1000-magnitude stream until avg settles, then inject mag 4000. That sample blanks; mag 2500 does not.
  - Separately check that avg=0 never blanks.
- Statistics and reset: pkrst asserted in the same cycle as a large sample gives peak=0 and nbl=0. Asserting rstn low mid-stream clears every output immediately (asynchronously).

Source files
------------

// File: rtl/noiseblanker2.sv
// noiseblanker2 - impulse noise blanker for the complex (I/Q) baseband path.
//
// Each sample's magnitude is estimated as max(|x|,|y|) + min(|x|,|y|)/2.
// A sample is flagged as an impulse when its magnitude exceeds an absolute
// limit or a multiple of a running average. Samples pass through a DEPTH-deep
// look-ahead delay line, so blanking starts DEPTH samples before the impulse
// emerges and runs HOLD samples past it. A blanked sample is zeroed or
// replaced by the last good output. Bypass mode passes everything through.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   dix, diy     I/Q input sample (two's complement, W bits)
//   iv           input valid strobe
//   limit        threshold: mag12 units (rel=0) or avg/16 units (rel=1)
//   rel          threshold select, 0 = absolute, 1 = relative
//   mode         00 bypass, 01 zero, 10 hold last good, 11 zero
//   pkrst        clears peak/nbl; travels with the sample entered with it
//   dox, doy     I/Q output sample, held between ov strobes
//   ov           output valid, three cycles after iv
//   peak         max mag12 since the last pkrst
//   nbl          impulse count since the last pkrst, saturating
module noiseblanker2 #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  parameter int HOLD  = 4,
  parameter int AVGSH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] dix,
  input  logic [W-1:0] diy,
  input  logic         iv,
  input  logic [11:0]  limit,
  input  logic         rel,
  input  logic [1:0]   mode,
  input  logic         pkrst,
  output logic [W-1:0] dox,
  output logic [W-1:0] doy,
  output logic         ov,
  output logic [11:0]  peak,
  output logic [15:0]  nbl
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW0 = $clog2(DEPTH + HOLD + 2);
  localparam int CW  = (CW0 < 8) ? 8 : CW0;
  // Loaded with DEPTH+HOLD because the impulse's own output is already counted.
  localparam logic [CW-1:0] BLANK_LOAD = CW'(DEPTH + HOLD);

  // |v| with the most negative code saturated to the largest positive value.
  function automatic logic [W-2:0] abs_sat(input logic [W-1:0] v);
    if (v == {1'b1, {(W-1){1'b0}}}) begin
      abs_sat = {(W-1){1'b1}};
    end else if (v[W-1]) begin
      abs_sat = ~v[W-2:0] + {{(W-2){1'b0}}, 1'b1};
    end else begin
      abs_sat = v[W-2:0];
    end
  endfunction

  // stage A: registered input
  logic [W-1:0] xa_r, ya_r;
  logic         va_r, pka_r;
  // stage B: magnitude plus the sample itself
  logic [W:0]   magb_r;
  logic [W-1:0] xb_r, yb_r;
  logic         vb_r, pkb_r;
  // state
  logic [W:0]   avg_r;
  logic [CW-1:0] cnt_r;
  logic [AW-1:0] wp_r;
  logic [W-1:0] memx_r [DEPTH];
  logic [W-1:0] memy_r [DEPTH];
  logic [W-1:0] holdx_r, holdy_r;

  logic [W-2:0] ax_s, ay_s, mx_s, mn_s, mn_half_s;
  logic [W:0]   mag_s;
  logic [11:0]  mag12_s;
  logic [W+12:0] prod_s, magsh_s;
  logic         pulse_s, blank_s, repl_s;
  logic signed [W+1:0] diff_s, step_s, sum_s;
  logic [W:0]   avg_nx_s;
  logic [W-1:0] dlyx_s, dlyy_s, selx_s, sely_s;

  // Input register stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xa_r <= {W{1'b0}};
      ya_r <= {W{1'b0}};
      va_r <= 1'b0;
      pka_r <= 1'b0;
    end else begin
      xa_r <= dix;
      ya_r <= diy;
      va_r <= iv;
      pka_r <= pkrst;
    end
  end

  // Magnitude estimate from the registered input.
  always_comb begin
    ax_s = abs_sat(xa_r);
    ay_s = abs_sat(ya_r);
    if (ax_s >= ay_s) begin
      mx_s = ax_s;
      mn_s = ay_s;
    end else begin
      mx_s = ay_s;
      mn_s = ax_s;
    end
    mn_half_s = mn_s >> 1;
    mag_s = {2'b00, mx_s} + {2'b00, mn_half_s};
  end

  // Magnitude register stage; the sample travels alongside toward the delay line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      magb_r <= {(W+1){1'b0}};
      xb_r <= {W{1'b0}};
      yb_r <= {W{1'b0}};
      vb_r <= 1'b0;
      pkb_r <= 1'b0;
    end else begin
      magb_r <= mag_s;
      xb_r <= xa_r;
      yb_r <= ya_r;
      vb_r <= va_r;
      pkb_r <= pka_r;
    end
  end

  // Impulse decision, averager step and blank decision for the stage-B sample.
  always_comb begin
    mag12_s = magb_r[W:W-11];
    prod_s  = {12'b0, avg_r} * {{(W+1){1'b0}}, limit};
    magsh_s = {8'b0, magb_r, 4'b0000};
    if (!vb_r) begin
      pulse_s = 1'b0;
    end else if (rel) begin
      pulse_s = (avg_r != {(W+1){1'b0}}) && (magsh_s > prod_s);
    end else begin
      pulse_s = mag12_s > limit;
    end
    diff_s = $signed({1'b0, magb_r}) - $signed({1'b0, avg_r});
    step_s = diff_s >>> AVGSH;
    sum_s  = $signed({1'b0, avg_r}) + step_s;
    // sum never goes negative; the clamp only guards against corrupted state
    if (sum_s[W+1]) begin
      avg_nx_s = {(W+1){1'b0}};
    end else begin
      avg_nx_s = sum_s[W:0];
    end
    // a pulse on this very sample blanks it even though the counter is still idle
    blank_s = pulse_s || (cnt_r != {CW{1'b0}});
    dlyx_s  = memx_r[wp_r];
    dlyy_s  = memy_r[wp_r];
  end

  // Output selection between delayed sample, zero and the last good sample.
  always_comb begin
    selx_s = dlyx_s;
    sely_s = dlyy_s;
    repl_s = 1'b0;
    case (mode)
      2'b00: begin
        repl_s = 1'b0;
      end
      2'b10: begin
        if (blank_s) begin
          repl_s = 1'b1;
          selx_s = holdx_r;
          sely_s = holdy_r;
        end else begin
          repl_s = 1'b0;
        end
      end
      default: begin
        if (blank_s) begin
          repl_s = 1'b1;
          selx_s = {W{1'b0}};
          sely_s = {W{1'b0}};
        end else begin
          repl_s = 1'b0;
        end
      end
    endcase
  end

  // Look-ahead delay line: read the oldest entry, then overwrite it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_r <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        memx_r[i] <= {W{1'b0}};
        memy_r[i] <= {W{1'b0}};
      end
    end else if (vb_r) begin
      memx_r[wp_r] <= xb_r;
      memy_r[wp_r] <= yb_r;
      wp_r <= wp_r + AW'(1);
    end
  end

  // Averager, blank counter, hold register and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      avg_r <= {(W+1){1'b0}};
      cnt_r <= {CW{1'b0}};
      holdx_r <= {W{1'b0}};
      holdy_r <= {W{1'b0}};
      dox <= {W{1'b0}};
      doy <= {W{1'b0}};
      ov <= 1'b0;
    end else begin
      ov <= vb_r;
      if (vb_r) begin
        avg_r <= avg_nx_s;
        if (pulse_s) begin
          cnt_r <= BLANK_LOAD;
        end else if (cnt_r != {CW{1'b0}}) begin
          cnt_r <= cnt_r - CW'(1);
        end
        dox <= selx_s;
        doy <= sely_s;
        if (!repl_s) begin
          holdx_r <= dlyx_s;
          holdy_r <= dlyy_s;
        end
      end
    end
  end

  // Peak and impulse statistics; pkrst wins over the sample it travels with.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak <= 12'd0;
      nbl <= 16'd0;
    end else if (pkb_r) begin
      peak <= 12'd0;
      nbl <= 16'd0;
    end else if (vb_r) begin
      if (mag12_s > peak) begin
        peak <= mag12_s;
      end
      if (pulse_s && (nbl != 16'hFFFF)) begin
        nbl <= nbl + 16'd1;
      end
    end
  end

endmodule
